// File: rtl/riscv_ctrl_if.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_if
// Purpose : Bundles every non-clock signal of the machine-mode control/CSR
//           block into one interface. The core datapath (master) drives the
//           CSR access bus, the instruction events and the interrupt lines.
//           The controller (slave) returns CSR read data, the trap request and
//           the trap/return targets.
// Signals :
//   csr[11:0]            CSR address
//   csr_mask[31:0]       write-bit mask, all-zero means no write
//   csr_wb[31:0]         CSR write data
//   csr_value[31:0]      combinational CSR read data
//   pc_datapath[31:0]    PC of the executing instruction
//   pc_ctrl[31:0]        fetch PC
//   jump                 executing instruction redirects
//   is_mem_op            executing instruction is a memory access
//   dmem_op[2:0]         memory operation encoding
//   addr[31:0]           data address
//   illegal_instruction, ucoded_instruction, breakpoint, ecall, mret, xret, wfi
//                        single-cycle instruction events
//   hardware_irq, timer_irq
//                        level-sensitive interrupt lines
//   trap                 take a trap this cycle
//   trap_target[31:0]    trap vector
//   mret_target[31:0]    return address for mret
//   xret_target[31:0]    return address for xret
// -----------------------------------------------------------------------------
interface riscv_ctrl_if;
   logic [11:0] csr;
   logic [31:0] csr_mask;
   logic [31:0] csr_wb;
   logic [31:0] csr_value;
   logic [31:0] pc_datapath;
   logic [31:0] pc_ctrl;
   logic        jump;
   logic        is_mem_op;
   logic [2:0]  dmem_op;
   logic [31:0] addr;
   logic        illegal_instruction;
   logic        ucoded_instruction;
   logic        breakpoint;
   logic        ecall;
   logic        mret;
   logic        xret;
   logic        wfi;
   logic        hardware_irq;
   logic        timer_irq;
   logic        trap;
   logic [31:0] trap_target;
   logic [31:0] mret_target;
   logic [31:0] xret_target;

   modport master (
      output csr, csr_mask, csr_wb, pc_datapath, pc_ctrl, jump, is_mem_op,
             dmem_op, addr, illegal_instruction, ucoded_instruction,
             breakpoint, ecall, mret, xret, wfi, hardware_irq, timer_irq,
      input  csr_value, trap, trap_target, mret_target, xret_target
   );

   modport slave (
      input  csr, csr_mask, csr_wb, pc_datapath, pc_ctrl, jump, is_mem_op,
             dmem_op, addr, illegal_instruction, ucoded_instruction,
             breakpoint, ecall, mret, xret, wfi, hardware_irq, timer_irq,
      output csr_value, trap, trap_target, mret_target, xret_target
   );
endinterface

// File: rtl/riscv_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_ctrl
// Purpose : Machine-mode trap and CSR controller for a small RISC-V core.
//           Detects exceptions and interrupts, raises a combinational trap in
//           the same cycle, updates mepc/mcause/mtval/mstatus on the following
//           edge, and implements the machine CSR file with masked writes.
// Ports   :
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   riscv_ctrl_if.slave, CSR bus, instruction events, irqs, trap outputs
// Config  :
//   RISCV_CTRL_UCODE_EN  when defined, ucoded_instruction traps to utvec
//                        (CSR 0x7C1) and saves the PC in uepc (CSR 0x7C0),
//                        leaving the machine trap state untouched, and
//                        xret_target returns uepc. When undefined,
//                        ucoded_instruction is an illegal instruction and
//                        0x7C0/0x7C1 are unmapped.
// -----------------------------------------------------------------------------
module riscv_ctrl (
   input logic         clk,
   input logic         rst,
   riscv_ctrl_if.slave bus
);

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;
`ifdef RISCV_CTRL_UCODE_EN
   localparam logic [11:0] CSR_UEPC      = 12'h7C0;
   localparam logic [11:0] CSR_UTVEC     = 12'h7C1;
`endif
   localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
   localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TIM_IRQ = 32'h8000_0007;

   logic        r_mie;
   logic        r_mpie;
   logic        r_mieExt;
   logic        r_mieTim;
   logic [29:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [29:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;
`ifdef RISCV_CTRL_UCODE_EN
   logic [31:0] r_uepc;
   logic [31:0] r_utvec;
`endif

   logic [31:0] w_mstatus;
   logic [31:0] w_mieVal;
   logic [31:0] w_mipVal;
   logic [31:0] w_readVal;
   logic [31:0] w_newVal;
   logic [1:0]  w_pending;
   logic        w_misaligned;
   logic        w_excAny;
   logic        w_excValid;
   logic        w_ucodeTrap;
   logic        w_irqTake;
   logic        w_trap;
   logic        w_csrWrite;
   logic [31:0] w_cause;
   logic [31:0] w_tval;
   logic [29:0] w_pcNextWord;
   logic        w_unused;

   // Architectural views of the packed status/enable/pending registers.
   // MPP is hardwired to machine mode, so it always reads as 2'b11.
   assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
   assign w_mieVal  = {20'd0, r_mieExt, 3'd0, r_mieTim, 7'd0};
   assign w_mipVal  = {20'd0, bus.hardware_irq, 3'd0, bus.timer_irq, 7'd0};

   // Pending-and-enabled interrupts, external in bit 1 and timer in bit 0.
   assign w_pending = {bus.hardware_irq & r_mieExt, bus.timer_irq & r_mieTim};

   // Only half and word accesses can be misaligned; bit 2 of dmem_op tells
   // stores from loads, so the low two bits alone select the access size.
   assign w_misaligned = bus.is_mem_op &&
                         (((bus.dmem_op[1:0] == 2'b10) && bus.addr[0]) ||
                          ((bus.dmem_op[1:0] == 2'b11) && (bus.addr[1:0] != 2'b00)));

   // Any synchronous event that blocks interrupts this cycle. A ucoded
   // instruction is an exception in both builds: either it traps to utvec or
   // it is folded into the illegal-instruction case.
   assign w_excAny = bus.illegal_instruction | bus.ucoded_instruction |
                     bus.breakpoint | bus.ecall | w_misaligned;

   // An interrupt is taken only when globally enabled and the instruction is
   // neither faulting nor redirecting. A wfi with a pending interrupt falls
   // out of this naturally; a wfi without one never traps.
   assign w_irqTake = r_mie && (|w_pending) && !w_excAny && !bus.jump;

   // Exception priority chain. The ucoded branch only exists in the
   // microcode build; otherwise the event is merged into the illegal case.
   always_comb begin
      w_excValid  = 1'b0;
      w_ucodeTrap = 1'b0;
      w_cause     = 32'd0;
      w_tval      = 32'd0;
`ifdef RISCV_CTRL_UCODE_EN
      if (bus.illegal_instruction) begin
`else
      if (bus.illegal_instruction || bus.ucoded_instruction) begin
`endif
         w_excValid = 1'b1;
         w_cause    = 32'd2;
      end
`ifdef RISCV_CTRL_UCODE_EN
      else if (bus.ucoded_instruction) begin
         w_ucodeTrap = 1'b1;
      end
`endif
      else if (bus.breakpoint) begin
         w_excValid = 1'b1;
         w_cause    = 32'd3;
         w_tval     = bus.pc_datapath;
      end else if (bus.ecall) begin
         w_excValid = 1'b1;
         w_cause    = 32'd11;
      end else if (w_misaligned) begin
         w_excValid = 1'b1;
         w_cause    = bus.dmem_op[2] ? 32'd6 : 32'd4;
         w_tval     = bus.addr;
      end else if (w_irqTake) begin
         w_cause    = w_pending[1] ? CAUSE_EXT_IRQ : CAUSE_TIM_IRQ;
      end
   end

   // The trap is gated by reset so it drops the moment reset is asserted,
   // without waiting for a clock edge.
   assign w_trap       = rst && (w_excValid || w_ucodeTrap || w_irqTake);
   assign w_csrWrite   = (|bus.csr_mask) && !w_trap;
   assign w_pcNextWord = bus.pc_datapath[31:2] + 30'd1;

   assign bus.trap        = w_trap;
   assign bus.mret_target = {r_mepc, 2'b00};
`ifdef RISCV_CTRL_UCODE_EN
   assign bus.trap_target = w_ucodeTrap ? r_utvec : {r_mtvec, 2'b00};
   assign bus.xret_target = r_uepc;
`else
   assign bus.trap_target = {r_mtvec, 2'b00};
   assign bus.xret_target = 32'd0;
`endif

   // Fetch PC and xret are carried on the bus for the core's benefit but are
   // not needed to make trap decisions here.
   assign w_unused = ^{bus.pc_ctrl, bus.xret, bus.pc_datapath[1:0], w_ucodeTrap};

   // Combinational CSR read mux; unmapped addresses read as zero.
   always_comb begin
      w_readVal = 32'd0;
      case (bus.csr)
         CSR_MSTATUS:   w_readVal = w_mstatus;
         CSR_MISA:      w_readVal = MISA_VALUE;
         CSR_MIE:       w_readVal = w_mieVal;
         CSR_MTVEC:     w_readVal = {r_mtvec, 2'b00};
         CSR_MSCRATCH:  w_readVal = r_mscratch;
         CSR_MEPC:      w_readVal = {r_mepc, 2'b00};
         CSR_MCAUSE:    w_readVal = r_mcause;
         CSR_MTVAL:     w_readVal = r_mtval;
         CSR_MIP:       w_readVal = w_mipVal;
         CSR_MCYCLE:    w_readVal = r_mcycle[31:0];
         CSR_MCYCLEH:   w_readVal = r_mcycle[63:32];
         CSR_MINSTRET:  w_readVal = r_minstret[31:0];
         CSR_MINSTRETH: w_readVal = r_minstret[63:32];
         CSR_MHARTID:   w_readVal = 32'd0;
`ifdef RISCV_CTRL_UCODE_EN
         CSR_UEPC:      w_readVal = r_uepc;
         CSR_UTVEC:     w_readVal = r_utvec;
`endif
         default:       w_readVal = 32'd0;
      endcase
   end

   assign bus.csr_value = w_readVal;

   // Masked read-modify-write value. Starting from the read view means
   // read-only and hardwired bits simply fall away when the result is stored.
   assign w_newVal = (w_readVal & ~bus.csr_mask) | (bus.csr_wb & bus.csr_mask);

   // CSR state update. Assignments are ordered so later ones win: counters
   // first, then software writes, then mret, then trap entry. Software writes
   // are already blocked on trap cycles, so the trap update always prevails.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mieExt   <= 1'b0;
         r_mieTim   <= 1'b0;
         r_mtvec    <= 30'd0;
         r_mscratch <= 32'd0;
         r_mepc     <= 30'd0;
         r_mcause   <= 32'd0;
         r_mtval    <= 32'd0;
         r_mcycle   <= 64'd0;
         r_minstret <= 64'd0;
`ifdef RISCV_CTRL_UCODE_EN
         r_uepc     <= 32'd0;
         r_utvec    <= 32'h0000_0200;
`endif
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
         if (!w_trap && !bus.wfi) begin
            r_minstret <= r_minstret + 64'd1;
         end

         if (w_csrWrite) begin
            case (bus.csr)
               CSR_MSTATUS: begin
                  r_mie  <= w_newVal[3];
                  r_mpie <= w_newVal[7];
               end
               CSR_MIE: begin
                  r_mieExt <= w_newVal[11];
                  r_mieTim <= w_newVal[7];
               end
               CSR_MTVEC:     r_mtvec    <= w_newVal[31:2];
               CSR_MSCRATCH:  r_mscratch <= w_newVal;
               CSR_MEPC:      r_mepc     <= w_newVal[31:2];
               CSR_MCAUSE:    r_mcause   <= w_newVal;
               CSR_MTVAL:     r_mtval    <= w_newVal;
               CSR_MCYCLE:    r_mcycle   <= {r_mcycle[63:32], w_newVal};
               CSR_MCYCLEH:   r_mcycle   <= {w_newVal, r_mcycle[31:0]};
               CSR_MINSTRET:  r_minstret <= {r_minstret[63:32], w_newVal};
               CSR_MINSTRETH: r_minstret <= {w_newVal, r_minstret[31:0]};
`ifdef RISCV_CTRL_UCODE_EN
               CSR_UEPC:      r_uepc     <= w_newVal;
               CSR_UTVEC:     r_utvec    <= w_newVal;
`endif
               default: ;
            endcase
         end

         if (bus.mret && !w_trap) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end

         if (w_excValid || w_irqTake) begin
            r_mepc   <= w_irqTake ? w_pcNextWord : bus.pc_datapath[31:2];
            r_mcause <= w_cause;
            r_mtval  <= w_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end
`ifdef RISCV_CTRL_UCODE_EN
         if (w_ucodeTrap) begin
            r_uepc <= bus.pc_datapath;
         end
`endif
      end
   end

endmodule

// File: tb/tb_riscv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_ctrl
// Purpose : Self-checking bench for riscv_ctrl. Each scenario task pushes the
//           values it expects onto a scoreboard queue as it drives stimulus,
//           then pops and compares them as the DUT produces trap outputs or
//           CSR read data.
// -----------------------------------------------------------------------------
module tb_riscv_ctrl;

   logic clk = 1'b0;
   logic rst;

   riscv_ctrl_if bus ();

   riscv_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sbExp[$];
   string       sbName[$];
   logic [31:0] obs;
   logic [31:0] exp;
   string       nm;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every master-driven signal to its idle value.
   task automatic clearInputs();
      bus.csr                 = 12'h000;
      bus.csr_mask            = 32'd0;
      bus.csr_wb              = 32'd0;
      bus.pc_datapath         = 32'd0;
      bus.pc_ctrl             = 32'd0;
      bus.jump                = 1'b0;
      bus.is_mem_op           = 1'b0;
      bus.dmem_op             = 3'b000;
      bus.addr                = 32'd0;
      bus.illegal_instruction = 1'b0;
      bus.ucoded_instruction  = 1'b0;
      bus.breakpoint          = 1'b0;
      bus.ecall               = 1'b0;
      bus.mret                = 1'b0;
      bus.xret                = 1'b0;
      bus.wfi                 = 1'b0;
      bus.hardware_irq        = 1'b0;
      bus.timer_irq           = 1'b0;
   endtask

   // Record an expected value on the scoreboard.
   task automatic sbPush(input string name, input logic [31:0] value);
      sbName.push_back(name);
      sbExp.push_back(value);
   endtask

   // Combinational CSR read with no write.
   task automatic readCsr(input logic [11:0] a, output logic [31:0] v);
      bus.csr      = a;
      bus.csr_mask = 32'd0;
      #1;
      v = bus.csr_value;
   endtask

   // One CSR write cycle, returning just after the capturing edge.
   task automatic applyStimulus(input logic [11:0] a, input logic [31:0] m, input logic [31:0] d);
      bus.csr      = a;
      bus.csr_mask = m;
      bus.csr_wb   = d;
      tick();
      bus.csr_mask = 32'd0;
   endtask

   // Reset values, reset suppressing a would-be trap, and counter start.
   task automatic test_reset();
      rst = 1'b0;
      clearInputs();
      tick();
      tick();
      sbPush("reset_mstatus", 32'h0000_1800);
      sbPush("reset_trap_gated", 32'd0);
      sbPush("reset_mtvec", 32'd0);
      sbPush("reset_mepc", 32'd0);
      sbPush("reset_mcycle", 32'd0);
      sbPush("reset_misa", 32'h4000_0100);
      readCsr(12'h300, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.ecall = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.ecall = 1'b0;
      readCsr(12'h305, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'hB00, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h301, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      rst = 1'b1;
      tick();
      sbPush("mcycle_first_count", 32'd1);
      readCsr(12'hB00, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
   endtask

   // mtvec programming, ecall and breakpoint traps.
   task automatic test_ecall();
      tick();
      applyStimulus(12'h305, 32'hFFFF_FFFF, 32'h0000_0100);
      sbPush("ecall_trap", 32'd1);
      sbPush("ecall_target", 32'h0000_0100);
      bus.pc_datapath = 32'h0000_0040;
      bus.ecall       = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      obs = bus.trap_target;
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("ecall_mepc", 32'h0000_0040);
      sbPush("ecall_mcause", 32'd11);
      tick();
      bus.ecall = 1'b0;
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("brk_mcause", 32'd3);
      sbPush("brk_mtval", 32'h0000_0044);
      bus.pc_datapath = 32'h0000_0044;
      bus.breakpoint  = 1'b1;
      tick();
      bus.breakpoint = 1'b0;
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h343, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
   endtask

   // Misaligned store/load traps and the aligned/non-memory boundaries.
   task automatic test_misaligned();
      logic [2:0]  opTab   [5] = '{3'b111, 3'b010, 3'b111, 3'b010, 3'b111};
      logic [31:0] addrTab [5] = '{32'h1002, 32'h1001, 32'h1004, 32'h1002, 32'h1002};
      logic        memTab  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        trapTab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] causeTab[2] = '{32'd6, 32'd4};
      tick();
      for (int i = 0; i < 5; i++) begin
         sbPush($sformatf("misalign_trap_%0d", i), {31'd0, trapTab[i]});
         bus.is_mem_op = memTab[i];
         bus.dmem_op   = opTab[i];
         bus.addr      = addrTab[i];
         #1;
         obs = {31'd0, bus.trap};
         nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
         if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
         if (i < 2) begin
            sbPush($sformatf("misalign_mcause_%0d", i), causeTab[i]);
            sbPush($sformatf("misalign_mtval_%0d", i), addrTab[i]);
            tick();
            bus.is_mem_op = 1'b0;
            readCsr(12'h342, obs);
            nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
            if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
            readCsr(12'h343, obs);
            nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
            if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
         end
      end
      bus.is_mem_op = 1'b0;
      bus.dmem_op   = 3'b000;
   endtask

   // External interrupt entry followed by mret.
   task automatic test_irq_mret();
      tick();
      applyStimulus(12'h304, 32'hFFFF_FFFF, 32'h0000_0800);
      applyStimulus(12'h300, 32'hFFFF_FFFF, 32'h0000_0008);
      sbPush("irq_trap", 32'd1);
      sbPush("irq_mip", 32'h0000_0800);
      bus.pc_datapath  = 32'h0000_0020;
      bus.hardware_irq = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h344, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("irq_mcause", 32'h8000_000B);
      sbPush("irq_mepc", 32'h0000_0024);
      sbPush("irq_mstatus", 32'h0000_1880);
      sbPush("irq_mtval", 32'd0);
      tick();
      bus.hardware_irq = 1'b0;
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h300, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h343, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      sbPush("mret_target", 32'h0000_0024);
      sbPush("mret_mstatus", 32'h0000_1888);
      bus.mret = 1'b1;
      #1;
      obs = bus.mret_target;
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      bus.mret = 1'b0;
      readCsr(12'h300, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
   endtask

   // Simultaneous illegal/breakpoint/timer with a blocked mtvec write, then
   // the ucoded instruction in whichever build is active.
   task automatic test_priority();
      tick();
      sbPush("prio_trap", 32'd1);
      bus.pc_datapath         = 32'h0000_0080;
      bus.illegal_instruction = 1'b1;
      bus.breakpoint          = 1'b1;
      bus.timer_irq           = 1'b1;
      bus.csr                 = 12'h305;
      bus.csr_mask            = 32'hFFFF_FFFF;
      bus.csr_wb              = 32'h0000_0200;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("prio_mcause", 32'd2);
      sbPush("prio_mtval", 32'd0);
      sbPush("prio_mtvec_kept", 32'h0000_0100);
      tick();
      clearInputs();
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h343, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h305, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
`ifdef RISCV_CTRL_UCODE_EN
      sbPush("ucode_target", 32'h0000_0200);
      sbPush("ucode_mcause", 32'd2);
      sbPush("ucode_mepc", 32'h0000_0080);
`else
      sbPush("ucode_target", 32'h0000_0100);
      sbPush("ucode_mcause", 32'd2);
      sbPush("ucode_mepc", 32'h0000_0084);
`endif
      bus.pc_datapath        = 32'h0000_0084;
      bus.ucoded_instruction = 1'b1;
      #1;
      obs = bus.trap_target;
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      bus.ucoded_instruction = 1'b0;
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
   endtask

   // Timer interrupt blocked by jump, then taken; wfi with MIE clear.
   task automatic test_timer_jump_wfi();
      tick();
      applyStimulus(12'h304, 32'hFFFF_FFFF, 32'h0000_0080);
      applyStimulus(12'h300, 32'hFFFF_FFFF, 32'h0000_0008);
      sbPush("jump_blocks_irq", 32'd0);
      sbPush("timer_trap", 32'd1);
      bus.pc_datapath = 32'h0000_0090;
      bus.timer_irq   = 1'b1;
      bus.jump        = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.jump = 1'b0;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("timer_mcause", 32'h8000_0007);
      sbPush("timer_mepc", 32'h0000_0094);
      sbPush("wfi_no_trap", 32'd0);
      tick();
      readCsr(12'h342, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.wfi = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.wfi       = 1'b0;
      bus.timer_irq = 1'b0;
   endtask

   // Read-only, unmapped, hardwired and partially masked CSR accesses.
   task automatic test_csr_map();
      tick();
      sbPush("misa_readonly", 32'h4000_0100);
      sbPush("mtvec_low_bits", 32'h0000_0100);
      sbPush("mie_writable_bits", 32'h0000_0880);
      sbPush("mhartid", 32'd0);
      applyStimulus(12'h301, 32'hFFFF_FFFF, 32'd0);
      readCsr(12'h301, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      applyStimulus(12'h305, 32'hFFFF_FFFF, 32'h0000_0103);
      readCsr(12'h305, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      applyStimulus(12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      readCsr(12'h304, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'hF14, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      sbPush("mscratch_partial", 32'hAAAA_1234);
      applyStimulus(12'h340, 32'hFFFF_FFFF, 32'hAAAA_5555);
      applyStimulus(12'h340, 32'h0000_FFFF, 32'h1234_1234);
      readCsr(12'h340, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      sbPush("unmapped_no_trap", 32'd0);
      sbPush("unmapped_read", 32'd0);
      bus.csr      = 12'h7FF;
      bus.csr_mask = 32'hFFFF_FFFF;
      bus.csr_wb   = 32'h0000_1234;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      readCsr(12'h7FF, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      applyStimulus(12'h304, 32'hFFFF_FFFF, 32'd0);
   endtask

   // mcycle 64-bit carry and minstret write precedence / inhibit conditions.
   task automatic test_counters();
      logic [31:0] instTab[5] = '{32'h10, 32'h11, 32'h11, 32'h11, 32'h12};
      tick();
      applyStimulus(12'hB80, 32'hFFFF_FFFF, 32'd0);
      applyStimulus(12'hB00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      sbPush("mcycle_low_written", 32'hFFFF_FFFF);
      sbPush("mcycle_low_wrap", 32'd0);
      sbPush("mcycleh_carry", 32'd1);
      readCsr(12'hB00, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      readCsr(12'hB00, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'hB80, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      tick();
      for (int i = 0; i < 5; i++) begin
         sbPush($sformatf("minstret_step_%0d", i), instTab[i]);
      end
      applyStimulus(12'hB02, 32'hFFFF_FFFF, 32'h0000_0010);
      for (int i = 0; i < 5; i++) begin
         readCsr(12'hB02, obs);
         nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
         if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
         bus.wfi   = (i == 1);
         bus.ecall = (i == 2);
         tick();
         bus.wfi   = 1'b0;
         bus.ecall = 1'b0;
      end
   endtask

   // Reset asserted mid-cycle while a trap is being requested.
   task automatic test_async_reset();
      tick();
      sbPush("pre_reset_trap", 32'd1);
      sbPush("async_reset_trap", 32'd0);
      sbPush("async_reset_mepc", 32'd0);
      bus.pc_datapath = 32'h0000_0040;
      bus.ecall       = 1'b1;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      #2;
      rst = 1'b0;
      #1;
      obs = {31'd0, bus.trap};
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      readCsr(12'h341, obs);
      nm = sbName.pop_front(); exp = sbExp.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, obs, exp); end
      bus.ecall = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_misaligned();
      test_irq_mret();
      test_priority();
      test_timer_jump_wfi();
      test_csr_map();
      test_counters();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
